dbg_mem_arbiter: RTL and testbench
==================================

Name: dbg_mem_arbiter

Overview:
- Shares the processor's single-port synchronous data RAM between the CPU load/store port and a button-driven debug inspector.
- Each debounced button press advances a debug address, then fetches that word through the arbiter.
- The fetched word drives the 16-bit board display; ram_sel picks the low or high half.
- Sits between the CPU core and the data RAM, inside the processor top.

Parameters:
- AW, 8: RAM address width (words).
- DW, 32: RAM data width; must be >= 16.
- DB_CYCLES, 1000000: clock cycles the button must stay stable before a change is accepted.
- MAX_WAIT, 15: consecutive cycles a pending debug read may be blocked before it is forced through (only with ARB_STARVE_GUARD_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU memory access request
- cpu_we  in  1  CPU write enable (qualified by cpu_req)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  CPU access issued to RAM this cycle (combinational)
- cpu_rdata  out  DW  CPU read data
- cpu_rvalid  out  1  cpu_rdata valid; one cycle after a granted CPU read
- button  in  1  raw, asynchronous push button
- ram_sel  in  1  display half select: 0 = [15:0], 1 = [31:16]
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid one cycle after mem_en with mem_we=0
- out  out  16  display value

Behaviour:
- Reset (rst=0, async), all cleared:
  - debug address 0, pending flag 0, wait counter 0, debug word latch 0.
  - cpu_rvalid 0, out 0.
  - Debouncer state 0, counter 0.
- Button input path:
  - button passes through a 2-flop synchronizer.
  - The debounced level changes only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any bounce reloads the counter.
- Press handling: a rising edge of the debounced level sets dbg_pend and increments the debug address.
  - The address wraps modulo 2^AW: 2^AW-1 -> 0.
  - The first press after reset reads address 1.
- A rising edge while dbg_pend=1 still increments the address; the pending read then uses the newest address and no second read is queued.
- Arbitration, decided combinationally each cycle:
  - The debug read wins if dbg_pend=1 and either cpu_req=0 or the starvation guard fires. Otherwise the CPU wins if cpu_req=1.
  - CPU win: cpu_gnt=1; mem_* = cpu_*.
  - Debug win: mem_en=1, mem_we=0, mem_addr = debug address; dbg_pend clears at the clock edge.
  - Neither: mem_en=0, cpu_gnt=0.
- Read return:
  - A registered tag records the owner of the previous cycle's read.
  - CPU read: cpu_rvalid=1 for exactly one cycle, with cpu_rdata = mem_rdata.
  - Debug read: mem_rdata is latched into the debug word.
  - CPU writes never raise cpu_rvalid.
- Display: out = ram_sel ? word[31:16] : word[15:0]. It updates the cycle after the debug read data returns; a ram_sel change takes effect combinationally.
- Timing: a CPU request with no debug pending is granted in the same cycle, with 1-cycle read latency.
- Write then read: a CPU write in cycle N followed by a debug read of the same address in N+1 returns the new data (RAM write-first is not required; the arbiter serialises the accesses).
- Reset mid-access: any outstanding rvalid or latch update is discarded.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - A wait counter increments each cycle that dbg_pend=1 and the CPU is granted.
  - When the counter reaches MAX_WAIT, the next cycle grants debug regardless of cpu_req, and cpu_gnt=0 that cycle.
  - The counter clears on any debug grant.
- Undefined: strict CPU priority; a continuously requesting CPU may starve the debug read indefinitely. The counter is not instantiated.

Decomposition:
- Shared package: owner encoding (OWN_NONE, OWN_CPU, OWN_DBG) and the default AW/DW constants.
- One natural sub-module: btn_debounce (synchronizer, stable counter, rising-edge pulse), parameterised by DB_CYCLES. The arbiter and return path stay in the top.

Test Plan (DB_CYCLES=4 in simulation):
- Reset: hold rst=0 with button=1, then release -> out=0, cpu_rvalid=0, no press registered until button is held stable for 4 cycles after release.
- Press decode: RAM[1]=0xDEADBEEF; a clean press with no CPU traffic -> mem_addr=1 for one cycle. out=0xBEEF two cycles after the grant; ram_sel=1 -> out=0xDEAD.
- Bounce rejection: a button glitch of 2 cycles high -> no address increment; 2^AW-1 further presses wrap the next read to address 0.
- CPU priority: cpu_req held high with a read at address 5 while debug is pending -> cpu_gnt=1 every cycle and cpu_rvalid=1 one cycle after each grant; debug is granted the first cycle cpu_req=0.
- Starvation guard (macro defined, MAX_WAIT=3): cpu_req held high, press -> debug is granted on the 4th cycle after dbg_pend set, with cpu_gnt=0 that cycle. Without the macro, no debug grant while cpu_req=1.
- Write/read ordering: CPU writes 0x00001234 to address 2, then the debug read of address 2 -> out=0x1234.

Source files
------------

// File: rtl/dbg_mem_arbiter_pkg.sv
// dbg_mem_arbiter_pkg: shared owner encoding and default sizes for the debug memory arbiter
// No ports; imported by dbg_mem_arbiter and btn_debounce.
package dbg_mem_arbiter_pkg;
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;
endpackage

// File: rtl/dbg_mem_arbiter_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and rising-edge pulse for a push button
// Ports:
//   i_clk     clock
//   i_rst_n   asynchronous active-low reset
//   i_button  raw asynchronous button level
//   o_rise    one-cycle pulse when the debounced level goes 0 -> 1
module btn_debounce
    import dbg_mem_arbiter_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_button,
    output logic o_rise
);
    localparam int CW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);
    logic [1:0]    r_sync;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;
    logic          w_flip;
    // level flips on the DB_CYCLES-th consecutive cycle of disagreement
    assign w_flip = (r_sync[1] != r_level) && (r_cnt == CMAX);
    assign o_rise = r_rise;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_button};
            r_rise <= w_flip && r_sync[1];
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/dbg_mem_arbiter.sv
// dbg_mem_arbiter: shares the single-port data RAM between the CPU port and a button-driven debug reader
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
// Ports:
//   i_clk, i_rst_n                        clock, asynchronous active-low reset
//   i_cpu_req/we/addr/wdata               CPU access request
//   o_cpu_gnt, o_cpu_rdata, o_cpu_rvalid  CPU grant (combinational) and read return
//   i_button, i_ram_sel                   raw button, display half select
//   o_mem_en/we/addr/wdata, i_mem_rdata   RAM port (1-cycle read latency)
//   o_out                                 16-bit display value
module dbg_mem_arbiter
    import dbg_mem_arbiter_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int DB_CYCLES = 1000000,
    parameter int MAX_WAIT  = 15
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic          o_cpu_gnt,
    output logic [DW-1:0] o_cpu_rdata,
    output logic          o_cpu_rvalid,
    input  logic          i_button,
    input  logic          i_ram_sel,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic [15:0]   o_out
);
    logic          w_rise;
    logic          w_starve;
    logic          w_dbg_win;
    logic          w_cpu_win;
    logic [AW-1:0] r_dbg_addr;
    logic          r_pend;
    owner_t        r_owner;
    logic [DW-1:0] r_word;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_button (i_button),
        .o_rise   (w_rise)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] r_wait;
    // never passes MAX_WAIT: reaching it forces the debug grant, which clears it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_wait <= '0;
        else if (w_dbg_win)
            r_wait <= '0;
        else if (r_pend && w_cpu_win)
            r_wait <= r_wait + 1'b1;
    end
    assign w_starve = r_wait == WW'(MAX_WAIT);
`else
    assign w_starve = MAX_WAIT < 0;
`endif

    assign w_dbg_win    = r_pend && (!i_cpu_req || w_starve);
    assign w_cpu_win    = i_cpu_req && !w_dbg_win;
    assign o_cpu_gnt    = w_cpu_win;
    assign o_mem_en     = w_dbg_win || w_cpu_win;
    assign o_mem_we     = w_cpu_win && i_cpu_we;
    assign o_mem_addr   = w_dbg_win ? r_dbg_addr : i_cpu_addr;
    assign o_mem_wdata  = i_cpu_wdata;
    assign o_cpu_rdata  = i_mem_rdata;
    assign o_cpu_rvalid = r_owner == OWN_CPU;
    assign o_out        = i_ram_sel ? r_word[31:16] : r_word[15:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dbg_addr <= '0;
            r_pend     <= 1'b0;
            r_owner    <= OWN_NONE;
            r_word     <= '0;
        end else begin
            // a new press outranks the clear so the newest address is still read
            if (w_rise) begin
                r_pend     <= 1'b1;
                r_dbg_addr <= r_dbg_addr + 1'b1;
            end else if (w_dbg_win) begin
                r_pend <= 1'b0;
            end
            r_owner <= w_dbg_win ? OWN_DBG : (w_cpu_win && !i_cpu_we) ? OWN_CPU : OWN_NONE;
            if (r_owner == OWN_DBG)
                r_word <= i_mem_rdata;
        end
    end
endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// tb_dbg_mem_arbiter: directed self-checking bench for dbg_mem_arbiter with a behavioural RAM
module tb_dbg_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, cpu_req, cpu_we, button, ram_sel;
    logic [7:0]  cpu_addr, mem_addr;
    logic [31:0] cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
    logic        cpu_gnt, cpu_rvalid, mem_en, mem_we;
    logic [15:0] out;
    logic [31:0] ram [256];
    int          n_pass = 0, n_fail = 0, n_total = 0, n_dbg = 0, n0;
    logic [7:0]  last_dbg = '0;
    logic        found, all_a, all_b;

    dbg_mem_arbiter #(.AW(8), .DW(32), .DB_CYCLES(4), .MAX_WAIT(3)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_gnt    (cpu_gnt),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_rvalid (cpu_rvalid),
        .i_button     (button),
        .i_ram_sel    (ram_sel),
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_out        (out)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we)
                ram[mem_addr] <= mem_wdata;
            else
                mem_rdata <= ram[mem_addr];
        end

    // a RAM access without a CPU grant is a debug read
    always @(negedge clk)
        if (rst_n && mem_en && !cpu_gnt) begin
            n_dbg++;
            last_dbg = mem_addr;
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_dbg(input int lim, output logic f);
        f = 1'b0;
        for (int i = 0; i < lim && !f; i++) begin
            step();
            f = mem_en && !cpu_gnt;
        end
    endtask

    task automatic press();
        button = 1'b1;
        repeat (10) step();
        button = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        rst_n = 1'b0; button = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; ram_sel = 1'b0;
        step();
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_rvalid", 32'(cpu_rvalid), 32'h0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd1; cpu_wdata = 32'hDEADBEEF;
        #1 chk("rst_cpu_gnt", 32'(cpu_gnt), 32'h1);
        step();
        cpu_addr = 8'd0; cpu_wdata = 32'h0000A5A5;
        step();
        cpu_addr = 8'd5; cpu_wdata = 32'h55667788;
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("no_early_press", 32'(n_dbg), 32'd0);
        wait_dbg(20, found);
        chk("press_found", 32'(found), 32'h1);
        chk("press_addr", 32'(mem_addr), 32'd1);
        step();
        chk("one_cycle_grant", 32'(mem_en), 32'h0);
        step();
        chk("out_lo", 32'(out), 32'hBEEF);
        ram_sel = 1'b1;
        #1 chk("out_hi", 32'(out), 32'hDEAD);
        ram_sel = 1'b0;
        button = 1'b0;
        repeat (12) step();
        n0 = n_dbg;
        button = 1'b1;
        repeat (2) step();
        button = 1'b0;
        repeat (12) step();
        chk("glitch", 32'(n_dbg), 32'(n0));
        repeat (255) press();
        chk("wrap_count", 32'(n_dbg), 32'(n0 + 255));
        chk("wrap_addr", 32'(last_dbg), 32'd0);
        chk("wrap_out", 32'(out), 32'hA5A5);
        n0 = n_dbg;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd5;
        #1 chk("prio_gnt0", 32'(cpu_gnt), 32'h1);
        chk("prio_addr0", 32'(mem_addr), 32'd5);
        button = 1'b1;
        all_a = 1'b1; all_b = 1'b1;
`ifdef ARB_STARVE_GUARD_EN
        for (int i = 0; i < 9; i++) begin
            step();
            all_a &= cpu_gnt;
            all_b &= cpu_rvalid && (cpu_rdata == 32'h55667788);
        end
        chk("starve_cpu_gnt", 32'(all_a), 32'h1);
        chk("starve_cpu_rvalid", 32'(all_b), 32'h1);
        step();
        chk("starve_grant", 32'({mem_en, cpu_gnt}), 32'h2);
        chk("starve_addr", 32'(mem_addr), 32'd1);
        step();
        chk("starve_cpu_back", 32'(cpu_gnt), 32'h1);
        cpu_req = 1'b0;
`else
        for (int i = 0; i < 30; i++) begin
            step();
            all_a &= cpu_gnt;
            all_b &= cpu_rvalid && (cpu_rdata == 32'h55667788);
        end
        chk("prio_cpu_gnt", 32'(all_a), 32'h1);
        chk("prio_cpu_rvalid", 32'(all_b), 32'h1);
        chk("prio_no_dbg", 32'(n_dbg), 32'(n0));
        cpu_req = 1'b0;
        #1 chk("prio_dbg_grant", 32'({mem_en, cpu_gnt}), 32'h2);
        chk("prio_dbg_addr", 32'(mem_addr), 32'd1);
        chk("prio_last_rvalid", 32'(cpu_rvalid), 32'h1);
`endif
        button = 1'b0;
        repeat (12) step();
        chk("prio_dbg_count", 32'(n_dbg), 32'(n0 + 1));
        chk("prio_out", 32'(out), 32'hBEEF);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd2; cpu_wdata = 32'h00001234;
        button = 1'b1;
        all_a = 1'b1;
        repeat (7) begin
            step();
            all_a &= cpu_gnt && !cpu_rvalid;
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        #1 chk("wr_no_rvalid", 32'(all_a), 32'h1);
        chk("wr_dbg_grant", 32'({mem_en, cpu_gnt}), 32'h2);
        chk("wr_dbg_addr", 32'(mem_addr), 32'd2);
        step();
        chk("wr_dbg_no_rvalid", 32'(cpu_rvalid), 32'h0);
        step();
        chk("wr_out", 32'(out), 32'h1234);
        button = 1'b0;
        repeat (12) step();
        cpu_req = 1'b1; cpu_addr = 8'd5;
        step();
        chk("pre_rst_rvalid", 32'(cpu_rvalid), 32'h1);
        rst_n = 1'b0;
        #1 chk("mid_rst_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("mid_rst_out", 32'(out), 32'h0);
        cpu_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
